// File: rtl/wb_interconnect_pkg.sv
// Shared definitions for the Wishbone shared-bus interconnect.
// Holds the default bus widths, the FSM state encoding, the default slave memory map,
// and a helper for sizing the ack-timeout counter.
package wb_interconnect_pkg;

    localparam int unsigned AW_DEF    = 32;
    localparam int unsigned DW_DEF    = 32;
    localparam int unsigned NUM_S_DEF = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn  = 2'd1,
        StErr  = 2'd2
    } wb_state_e;

    // Slave 0 occupies the least significant AW bits.
    localparam logic [NUM_S_DEF*AW_DEF-1:0] SLV_BASE_DEF =
        {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NUM_S_DEF*AW_DEF-1:0] SLV_MASK_DEF = {4{32'hF000_0000}};

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_interconnect_if.sv
// Bundle of the master-side and slave-side Wishbone signals of the interconnect.
// Names carry the interconnect's own direction suffix (_i into it, _o out of it).
//   ic     : view taken by the interconnect
//   master : view taken by the bus masters (CPU ports, DMA)
//   slave  : view taken by the peripheral slaves
interface wb_interconnect_if #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned NUM_S = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned SW    = DW / 8
);
    logic [NUM_M-1:0]    m_cyc_i;
    logic [NUM_M-1:0]    m_stb_i;
    logic [NUM_M-1:0]    m_we_i;
    logic [NUM_M*AW-1:0] m_addr_i;
    logic [NUM_M*DW-1:0] m_data_i;
    logic [NUM_M*SW-1:0] m_sel_i;
    logic [DW-1:0]       m_data_o;
    logic [NUM_M-1:0]    m_ack_o;
    logic [NUM_M-1:0]    m_err_o;

    logic [NUM_S-1:0]    s_cyc_o;
    logic [NUM_S-1:0]    s_stb_o;
    logic                s_we_o;
    logic [AW-1:0]       s_addr_o;
    logic [DW-1:0]       s_data_o;
    logic [SW-1:0]       s_sel_o;
    logic [NUM_S*DW-1:0] s_data_i;
    logic [NUM_S-1:0]    s_ack_i;
    logic [NUM_S-1:0]    s_err_i;

    modport ic (
        input  m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        output m_data_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
        input  s_data_i, s_ack_i, s_err_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        input  m_data_o, m_ack_o, m_err_o
    );

    modport slave (
        input  s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_data_o, s_sel_o,
        output s_data_i, s_ack_i, s_err_i
    );

endinterface

// File: rtl/wb_interconnect_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first requester at or after ptr_i (wrapping) and returns the pointer
// that follows the winner.
//   req_i   : request vector
//   ptr_i   : current round-robin pointer
//   gnt_o   : one-hot winner (0 when no request)
//   ptr_o   : winner + 1 mod NUM_M (ptr_i when no request)
//   valid_o : at least one request present
module wb_interconnect_rr_arbiter #(
    parameter int unsigned NUM_M = 2,
    parameter int unsigned PW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
    input  logic [NUM_M-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [NUM_M-1:0] gnt_o,
    output logic [PW-1:0]    ptr_o,
    output logic             valid_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < int'(NUM_M); k++) begin
            idx = (int'(ptr_i) + k) % int'(NUM_M);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_o      = PW'((idx + 1) % int'(NUM_M));
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/wb_interconnect.sv
// Wishbone shared-bus interconnect: NUM_M masters onto NUM_S slaves.
// Round-robin arbitration with cycle lock, base/mask address decode, one-cycle
// error response on decode miss or ack timeout.
//   clk     : bus clock
//   rst_n   : asynchronous active-low reset
//   bus     : master- and slave-side Wishbone signals (ic modport)
//   grant_o : one-hot registered bus owner, 0 when idle
//   busy_o  : bus currently owned
module wb_interconnect
    import wb_interconnect_pkg::*;
#(
    parameter int unsigned         NUM_M    = 2,
    parameter int unsigned         NUM_S    = NUM_S_DEF,
    parameter int unsigned         AW       = AW_DEF,
    parameter int unsigned         DW       = DW_DEF,
    parameter int unsigned         SW       = DW / 8,
    parameter int unsigned         TIMEOUT  = 255,
    parameter logic [NUM_S*AW-1:0] SLV_BASE = SLV_BASE_DEF,
    parameter logic [NUM_S*AW-1:0] SLV_MASK = SLV_MASK_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_interconnect_if.ic    bus,
    output logic [NUM_M-1:0] grant_o,
    output logic             busy_o
);

    localparam int unsigned PW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int unsigned SIW = (NUM_S > 1) ? $clog2(NUM_S) : 1;
    localparam int unsigned CW  = cnt_width(TIMEOUT);

    wb_state_e        state_q, state_d;
    logic [NUM_M-1:0] grant_q, grant_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    tmo_q, tmo_d;

    logic             own_cyc, own_stb, own_we;
    logic [AW-1:0]    own_addr;
    logic [DW-1:0]    own_data;
    logic [SW-1:0]    own_sel;

    logic             sel_valid;
    logic [SIW-1:0]   sel_idx;
    logic             slv_ack, slv_err;

    logic [NUM_M-1:0] arb_gnt;
    logic [PW-1:0]    arb_ptr;
    logic             arb_valid;
    logic             rearb;

    // Owner mux: grant is one-hot or zero, so an OR-reduction selects the owner
    // and yields all-zero when idle.
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_addr = '0;
        own_data = '0;
        own_sel  = '0;
        for (int m = 0; m < int'(NUM_M); m++) begin
            if (grant_q[m]) begin
                own_cyc  = own_cyc | bus.m_cyc_i[m];
                own_stb  = own_stb | bus.m_stb_i[m];
                own_we   = own_we  | bus.m_we_i[m];
                own_addr = own_addr | bus.m_addr_i[m*AW +: AW];
                own_data = own_data | bus.m_data_i[m*DW +: DW];
                own_sel  = own_sel  | bus.m_sel_i[m*SW +: SW];
            end
        end
    end

    // Address decode; scanning downwards leaves the lowest matching index.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = int'(NUM_S) - 1; i >= 0; i--) begin
            if ((own_addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                sel_valid = |grant_q;
                sel_idx   = SIW'(i);
            end
        end
    end

    // Slave-side forwarding; strobe is withheld during the error cycle.
    always_comb begin
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        if (sel_valid) begin
            bus.s_cyc_o[sel_idx] = own_cyc;
            bus.s_stb_o[sel_idx] = own_stb && (state_q != StErr);
        end
    end

    assign bus.s_we_o   = own_we;
    assign bus.s_addr_o = own_addr;
    assign bus.s_data_o = own_data;
    assign bus.s_sel_o  = own_sel;

    // Responses only count from the selected slave while a strobe is active.
    assign slv_ack = sel_valid && own_stb && (state_q == StOwn) && bus.s_ack_i[sel_idx];
    assign slv_err = sel_valid && own_stb && (state_q == StOwn) && bus.s_err_i[sel_idx];

    assign bus.m_ack_o  = grant_q & {NUM_M{slv_ack && !slv_err}};
    assign bus.m_err_o  = grant_q & {NUM_M{slv_err || (state_q == StErr)}};
    assign bus.m_data_o = sel_valid ? bus.s_data_i[int'(sel_idx)*DW +: DW] : '0;

    wb_interconnect_rr_arbiter #(
        .NUM_M (NUM_M),
        .PW    (PW)
    ) u_arb (
        .req_i   (bus.m_cyc_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .ptr_o   (arb_ptr),
        .valid_o (arb_valid)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        tmo_d   = '0;
        rearb   = 1'b0;
        unique case (state_q)
            StIdle: rearb = 1'b1;
            StOwn: begin
                if (!own_cyc) begin
                    rearb = 1'b1;
                end else if (own_stb && !sel_valid) begin
                    state_d = StErr;
                end else if (own_stb && !slv_ack && !slv_err) begin
                    if (tmo_q == CW'(TIMEOUT - 1)) begin
                        state_d = StErr;
                    end else begin
                        tmo_d = tmo_q + CW'(1);
                    end
                end
            end
            StErr: begin
                if (!own_cyc) begin
                    rearb = 1'b1;
                end else begin
                    state_d = StOwn;
                end
            end
            default: state_d = StIdle;
        endcase
        // Re-arbitration happens on the same edge the owner releases cyc.
        if (rearb) begin
            if (arb_valid) begin
                state_d = StOwn;
                grant_d = arb_gnt;
                ptr_d   = arb_ptr;
            end else begin
                state_d = StIdle;
                grant_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed self-checking bench for wb_interconnect (2 masters, 4 slaves, TIMEOUT = 4).
module tb_wb_interconnect;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;
    logic       busy;
    int         n_cmp = 0;
    int         n_fail = 0;

    wb_interconnect_if #(.NUM_M(2), .NUM_S(4), .AW(32), .DW(32)) bus ();

    wb_interconnect #(
        .NUM_M   (2),
        .NUM_S   (4),
        .AW      (32),
        .DW      (32),
        .TIMEOUT (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        bus.m_cyc_i  = '0;
        bus.m_stb_i  = '0;
        bus.m_we_i   = '0;
        bus.m_addr_i = '0;
        bus.m_data_i = '0;
        bus.m_sel_i  = '0;
        bus.s_data_i = '0;
        bus.s_ack_i  = '0;
        bus.s_err_i  = '0;
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] sel);
        bus.m_cyc_i[m]          = cyc;
        bus.m_stb_i[m]          = stb;
        bus.m_we_i[m]           = we;
        bus.m_addr_i[m*32 +: 32] = addr;
        bus.m_data_i[m*32 +: 32] = data;
        bus.m_sel_i[m*4 +: 4]   = sel;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (grant !== 2'b00) begin n_fail++;
            $display("FAIL rst_grant: got %b want 00", grant); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++;
            $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (bus.s_stb_o !== 4'b0000 || bus.s_cyc_o !== 4'b0000) begin n_fail++;
            $display("FAIL rst_slave: got %b/%b want 0000/0000", bus.s_cyc_o, bus.s_stb_o); end
        n_cmp++; if (bus.m_ack_o !== 2'b00 || bus.m_err_o !== 2'b00) begin n_fail++;
            $display("FAIL rst_resp: got %b/%b want 00/00", bus.m_ack_o, bus.m_err_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        clear_inputs();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'hF);
        #1;
        n_cmp++; if (grant !== 2'b00) begin n_fail++;
            $display("FAIL rd_latency: got %b want 00", grant); end
        step();
        n_cmp++; if (grant !== 2'b01 || busy !== 1'b1) begin n_fail++;
            $display("FAIL rd_grant: got %b/%b want 01/1", grant, busy); end
        n_cmp++; if (bus.s_stb_o !== 4'b0001 || bus.s_cyc_o !== 4'b0001) begin n_fail++;
            $display("FAIL rd_stb: got %b/%b want 0001/0001", bus.s_cyc_o, bus.s_stb_o); end
        n_cmp++; if (bus.s_addr_o !== 32'h0000_0010 || bus.s_we_o !== 1'b0) begin n_fail++;
            $display("FAIL rd_addr: got %h/%b want 00000010/0", bus.s_addr_o, bus.s_we_o); end
        n_cmp++; if (bus.m_ack_o !== 2'b00) begin n_fail++;
            $display("FAIL rd_noack: got %b want 00", bus.m_ack_o); end
        step();
        bus.s_data_i[31:0] = 32'hDEAD_BEEF;
        bus.s_ack_i[0]     = 1'b1;
        #1;
        n_cmp++; if (bus.m_ack_o !== 2'b01) begin n_fail++;
            $display("FAIL rd_ack: got %b want 01", bus.m_ack_o); end
        n_cmp++; if (bus.m_data_o !== 32'hDEAD_BEEF) begin n_fail++;
            $display("FAIL rd_data: got %h want deadbeef", bus.m_data_o); end
        step();
        clear_inputs();
        step();
        n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++;
            $display("FAIL rd_release: got %b/%b want 00/0", grant, busy); end
    endtask

    task automatic test_arbitration();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.m_cyc_i = 2'b11;
        step();
        n_cmp++; if (grant !== 2'b01) begin n_fail++;
            $display("FAIL arb_first: got %b want 01", grant); end
        bus.m_cyc_i[0] = 1'b0;
        step();
        n_cmp++; if (grant !== 2'b10 || busy !== 1'b1) begin n_fail++;
            $display("FAIL arb_handover: got %b/%b want 10/1", grant, busy); end
        bus.m_cyc_i[0] = 1'b1;
        step();
        n_cmp++; if (grant !== 2'b10) begin n_fail++;
            $display("FAIL arb_lock: got %b want 10", grant); end
        bus.m_cyc_i[1] = 1'b0;
        step();
        n_cmp++; if (grant !== 2'b01) begin n_fail++;
            $display("FAIL arb_rr: got %b want 01", grant); end
        clear_inputs();
        step();
        n_cmp++; if (grant !== 2'b00) begin n_fail++;
            $display("FAIL arb_idle: got %b want 00", grant); end
    endtask

    task automatic test_write();
        clear_inputs();
        set_m(1, 1'b1, 1'b0, 1'b1, 32'h2000_0004, 32'h0000_0055, 4'b0001);
        bus.s_ack_i[2] = 1'b1;
        step();
        n_cmp++; if (grant !== 2'b10) begin n_fail++;
            $display("FAIL wr_grant: got %b want 10", grant); end
        n_cmp++; if (bus.m_ack_o !== 2'b00 || bus.s_stb_o !== 4'b0000) begin n_fail++;
            $display("FAIL wr_stb_low_ack: got %b/%b want 00/0000", bus.m_ack_o, bus.s_stb_o); end
        bus.m_stb_i[1] = 1'b1;
        bus.s_ack_i[0] = 1'b1;
        #1;
        n_cmp++; if (bus.s_stb_o !== 4'b0100 || bus.s_cyc_o !== 4'b0100) begin n_fail++;
            $display("FAIL wr_stb: got %b/%b want 0100/0100", bus.s_cyc_o, bus.s_stb_o); end
        n_cmp++; if (bus.s_we_o !== 1'b1 || bus.s_sel_o !== 4'b0001) begin n_fail++;
            $display("FAIL wr_we_sel: got %b/%b want 1/0001", bus.s_we_o, bus.s_sel_o); end
        n_cmp++; if (bus.s_data_o !== 32'h55 || bus.s_addr_o !== 32'h2000_0004) begin n_fail++;
            $display("FAIL wr_data: got %h/%h want 00000055/20000004",
                     bus.s_data_o, bus.s_addr_o); end
        n_cmp++; if (bus.m_ack_o !== 2'b10) begin n_fail++;
            $display("FAIL wr_ack: got %b want 10", bus.m_ack_o); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_decode_miss();
        clear_inputs();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        step();
        n_cmp++; if (grant !== 2'b01 || bus.s_stb_o !== 4'b0000) begin n_fail++;
            $display("FAIL miss_nostb: got %b/%b want 01/0000", grant, bus.s_stb_o); end
        n_cmp++; if (bus.m_err_o !== 2'b00) begin n_fail++;
            $display("FAIL miss_early: got %b want 00", bus.m_err_o); end
        step();
        n_cmp++; if (bus.m_err_o !== 2'b01 || bus.m_ack_o !== 2'b00) begin n_fail++;
            $display("FAIL miss_err: got %b/%b want 01/00", bus.m_err_o, bus.m_ack_o); end
        step();
        n_cmp++; if (bus.m_err_o !== 2'b00) begin n_fail++;
            $display("FAIL miss_onecycle: got %b want 00", bus.m_err_o); end
        clear_inputs();
        step();
        n_cmp++; if (grant !== 2'b00) begin n_fail++;
            $display("FAIL miss_release: got %b want 00", grant); end
    endtask

    task automatic test_timeout();
        clear_inputs();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'hF);
        step();
        n_cmp++; if (grant !== 2'b01 || bus.s_stb_o !== 4'b0010) begin n_fail++;
            $display("FAIL tmo_start: got %b/%b want 01/0010", grant, bus.s_stb_o); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (bus.m_err_o !== 2'b00) begin n_fail++;
                $display("FAIL tmo_wait%0d: got %b want 00", k, bus.m_err_o); end
        end
        step();
        n_cmp++; if (bus.m_err_o !== 2'b01) begin n_fail++;
            $display("FAIL tmo_err: got %b want 01", bus.m_err_o); end
        n_cmp++; if (bus.s_stb_o !== 4'b0000 || bus.s_cyc_o !== 4'b0010) begin n_fail++;
            $display("FAIL tmo_stb_low: got %b/%b want 0010/0000", bus.s_cyc_o, bus.s_stb_o); end
        step();
        n_cmp++; if (bus.m_err_o !== 2'b00 || bus.s_stb_o !== 4'b0010) begin n_fail++;
            $display("FAIL tmo_resume: got %b/%b want 00/0010", bus.m_err_o, bus.s_stb_o); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (bus.m_err_o !== 2'b00) begin n_fail++;
                $display("FAIL tmo_rewait%0d: got %b want 00", k, bus.m_err_o); end
        end
        step();
        n_cmp++; if (bus.m_err_o !== 2'b01) begin n_fail++;
            $display("FAIL tmo_restart: got %b want 01", bus.m_err_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_err_priority();
        clear_inputs();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'hF);
        bus.s_ack_i[3] = 1'b1;
        bus.s_err_i[3] = 1'b1;
        step();
        n_cmp++; if (bus.s_stb_o !== 4'b1000) begin n_fail++;
            $display("FAIL errpri_stb: got %b want 1000", bus.s_stb_o); end
        n_cmp++; if (bus.m_ack_o !== 2'b00 || bus.m_err_o !== 2'b10) begin n_fail++;
            $display("FAIL errpri_resp: got %b/%b want 00/10", bus.m_ack_o, bus.m_err_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
        bus.s_data_i[31:0] = 32'h1111_1111;
        bus.s_ack_i[0]     = 1'b1;
        step();
        n_cmp++; if (grant !== 2'b01 || bus.m_ack_o !== 2'b01) begin n_fail++;
            $display("FAIL b2b_first: got %b/%b want 01/01", grant, bus.m_ack_o); end
        n_cmp++; if (bus.m_data_o !== 32'h1111_1111) begin n_fail++;
            $display("FAIL b2b_data1: got %h want 11111111", bus.m_data_o); end
        bus.m_cyc_i[1]     = 1'b1;
        bus.m_addr_i[31:0] = 32'h0000_0004;
        bus.s_data_i[31:0] = 32'h2222_2222;
        step();
        n_cmp++; if (grant !== 2'b01 || bus.m_ack_o !== 2'b01) begin n_fail++;
            $display("FAIL b2b_second: got %b/%b want 01/01", grant, bus.m_ack_o); end
        n_cmp++; if (bus.m_data_o !== 32'h2222_2222 || bus.s_addr_o !== 32'h4) begin n_fail++;
            $display("FAIL b2b_data2: got %h/%h want 22222222/00000004",
                     bus.m_data_o, bus.s_addr_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0, 4'hF);
        step();
        n_cmp++; if (grant !== 2'b01) begin n_fail++;
            $display("FAIL ar_pre: got %b want 01", grant); end
        bus.s_ack_i[0] = 1'b1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (grant !== 2'b00 || busy !== 1'b0) begin n_fail++;
            $display("FAIL ar_grant: got %b/%b want 00/0", grant, busy); end
        n_cmp++; if (bus.s_cyc_o !== 4'b0000 || bus.s_stb_o !== 4'b0000) begin n_fail++;
            $display("FAIL ar_slave: got %b/%b want 0000/0000", bus.s_cyc_o, bus.s_stb_o); end
        n_cmp++; if (bus.m_ack_o !== 2'b00 || bus.m_err_o !== 2'b00) begin n_fail++;
            $display("FAIL ar_resp: got %b/%b want 00/00", bus.m_ack_o, bus.m_err_o); end
        clear_inputs();
        bus.m_cyc_i = 2'b11;
        #1;
        rst_n = 1'b1;
        step();
        n_cmp++; if (grant !== 2'b01) begin n_fail++;
            $display("FAIL ar_restart: got %b want 01", grant); end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_read();
        test_arbitration();
        test_write();
        test_decode_miss();
        test_timeout();
        test_err_priority();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_interconnect.md
Name: wb_interconnect

Overview:
- Parametrised Wishbone shared-bus interconnect: NUM_M masters to NUM_S slaves.
- Provides round-robin arbitration with cycle lock, base/mask address decode, decode-miss error and ack-timeout error.
- Sits between the CPU bus ports (instruction and data, later DMA) and peripheral slaves (base/ext RAM, flash, UART, digit display).
- Replaces the fixed single-master bus decode.

Parameters:
- NUM_M, 2, number of masters
- NUM_S, 4, number of slaves
- AW, 32, address width
- DW, 32, data width
- SW, DW/8, byte-select width
- TIMEOUT, 255, max wait cycles for ack/err before abort (≥1)
- SLV_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, flattened NUM_S*AW base addresses, slave 0 in LSBs
- SLV_MASK, {4{32'hF000_0000}}, flattened NUM_S*AW decode masks

Ports:
- clk  in  1  bus clock
- rst  in  1  asynchronous reset, active-low
- m_cyc_i  in  NUM_M  per-master cycle request
- m_stb_i  in  NUM_M  per-master strobe
- m_we_i  in  NUM_M  per-master write enable
- m_addr_i  in  NUM_M*AW  per-master address
- m_data_i  in  NUM_M*DW  per-master write data
- m_sel_i  in  NUM_M*SW  per-master byte selects
- m_data_o  out  DW  read data, shared by all masters
- m_ack_o  out  NUM_M  per-master ack
- m_err_o  out  NUM_M  per-master error
- s_cyc_o  out  NUM_S  per-slave cycle
- s_stb_o  out  NUM_S  per-slave strobe
- s_we_o  out  1  shared write enable
- s_addr_o  out  AW  shared address
- s_data_o  out  DW  shared write data
- s_sel_o  out  SW  shared byte selects
- s_data_i  in  NUM_S*DW  per-slave read data
- s_ack_i  in  NUM_S  per-slave ack
- s_err_i  in  NUM_S  per-slave error
- grant_o  out  NUM_M  one-hot current owner, 0 when idle
- busy_o  out  1  bus owned

Behaviour:
- Reset (rst low, async): state IDLE, grant 0, RR pointer 0, timeout counter 0, all outputs 0. Reset mid-transfer drops grant and all strobes immediately; no ack or err is emitted.
- States:
  - IDLE: no owner.
  - OWN: grant registered.
  - ERR: one-cycle error response to owner.
- IDLE -> OWN at the clock edge after any m_cyc_i is seen high.
  - Winner = first requester at or after the RR pointer, wrapping.
  - Pointer <= winner+1 mod NUM_M.
- OWN holds while owner m_cyc_i is high (cycle lock; other requests wait).
- When owner cyc drops in OWN: re-arbitrate at that same edge. Next requester -> OWN with new grant; none -> IDLE. No idle gap is required.
- Request-to-grant latency: 1 cycle. grant_o/busy_o are registered.
- Forwarding in OWN: owner's we/addr/data/sel drive the s_* outputs, combinational from the registered grant. In IDLE, shared s_* outputs are 0.
- Decode (combinational): selected slave = lowest index i with (addr & MASK_i) == BASE_i.
  - s_cyc_o[i] = owner cyc; s_stb_o[i] = owner stb.
  - Other slaves are 0.
- Ack/err/data are combinational pass-through from the selected slave to the owner only. Zero added latency. m_data_o = selected slave data, else 0.
  - Acks from unselected slaves are ignored.
  - Ack while stb is low is ignored.
- Decode miss with owner stb high: no slave strobed; OWN -> ERR. In ERR, m_err_o[owner] = 1 for exactly one cycle, then back to OWN (cyc still high) or re-arbitrate.
- Timeout counter:
  - Increments each OWN cycle with stb high, a slave selected, and no ack/err.
  - Clears on ack, err, stb low, or grant change.
  - On reaching TIMEOUT: OWN -> ERR; s_stb_o is forced low during the ERR cycle.
- Simultaneous ack and err from a slave: err wins; ack is suppressed.
- Single owner: a lone master holding cyc over back-to-back strobes gets one transfer per ack with no re-arbitration.

Decomposition:
- Package wb_defs: AW/DW defaults, state encoding (IDLE/OWN/ERR), default SLV_BASE/SLV_MASK memory map, timeout counter width = clog2(TIMEOUT+1).
- Sub-module wb_rr_arbiter(NUM_M): request vector + pointer -> one-hot winner + next pointer, combinational.
- Decode and muxing stay in wb_interconnect.

Test Plan:
- Reset, then master0 reads 0x0000_0010 with slave0 acking after 2 cycles, data 0xDEADBEEF -> grant_o=01 one cycle after cyc; s_stb_o=0001; m_ack_o[0] with m_data_o=0xDEADBEEF; m_ack_o[1] stays 0.
- Both masters raise cyc in the same cycle, pointer 0 -> master0 granted. After master0 drops cyc, master1 is granted at that same edge. Next contention grants master0 again.
- Master1 writes 0x2000_0004, data 0x55, sel 0001 -> s_stb_o=0100, s_we_o=1, s_data_o=0x55, s_sel_o=0001; slave2 ack -> m_ack_o[1].
- Master0 accesses 0x8000_0000 (no match) -> no s_stb_o; m_err_o[0]=1 for exactly 1 cycle, one cycle after stb.
- TIMEOUT=4, slave1 never acks on 0x1000_0000 -> m_err_o[0] pulses after 4 waiting cycles; s_stb_o[1] low that cycle; counter restarts on the next strobe.
- Async rst low mid-transfer -> grant_o, busy_o, s_cyc_o, s_stb_o are 0 immediately, before the next edge. After release, arbitration restarts from master0.
